pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV32I pipeline. Combines three inputs:
//  - the load-use hazard flag (SignalPC) from the hazard unit
//  - the branch/jump redirect resolved in EX
//  - the data-memory handshake
//  From these it drives the enable/flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  It also holds the pipeline in a flushed boot state after reset and flags data-memory timeouts.
// PARAMETERS
//  BOOT_CYCLES  3   cycles pipeline held flushed after reset release (>=1)
//  MEM_TIMEOUT  64  max MEM_WAIT cycles before mem_err; 0 disables timeout
//  CNT_W        32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      async active-low reset
//  load_hazard   in   1      load-use hazard from hazard unit (SignalPC)
//  redirect_ex   in   1      taken branch / JAL / JALR resolved in EX
//  dmem_req      in   1      EX/MEM stage holds a load/store this cycle
//  dmem_ready    in   1      data memory completes the access this cycle
//  pc_en         out  1      PC register load enable
//  pc_sel_tgt    out  1      1: PC loads EX target, 0: PC+4
//  ifid_en       out  1      IF/ID register enable
//  ifid_flush    out  1      IF/ID clear to NOP (addi x0,x0,0)
//  idex_en       out  1      ID/EX enable
//  idex_flush    out  1      ID/EX clear controls (bubble)
//  exmem_en      out  1      EX/MEM enable
//  memwb_en      out  1      MEM/WB enable
//  mem_err       out  1      sticky: data-memory timeout occurred
//  state_o       out  2      current FSM state (debug)
// BEHAVIOUR
//  - FSM states: BOOT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, REDIRECT=2'd3. Outputs are Mealy (state + inputs), no latency.
//  - Reset (rst_n=0, async):
//    - state=BOOT, boot counter=BOOT_CYCLES-1, timeout counter=0, mem_err=0.
//    - All *_en=0, ifid_flush=idex_flush=1, pc_sel_tgt=0.
//  - BOOT: outputs as in reset. Counter decrements each cycle; at 0 go to RUN. PC stays at reset vector.
//  - RUN: priority mem stall > redirect > load hazard > normal.
//    - dmem_req & !dmem_ready: freeze all stages (all *_en=0, no flush); next state MEM_WAIT.
//    - redirect_ex (memory not stalling): pc_en=1, pc_sel_tgt=1, ifid_flush=1, idex_flush=1, other en=1.
//      Next state REDIRECT. load_hazard is ignored this cycle (the instruction is squashed).
//    - load_hazard: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Stay in RUN (one bubble per asserted cycle).
//    - Otherwise all *_en=1, no flush.
//  - MEM_WAIT: all *_en=0, flushes=0; timeout counter increments.
//    - dmem_ready: release this cycle with RUN outputs, re-evaluating redirect/hazard; go to RUN; counter=0.
//    - Counter reaching MEM_TIMEOUT-1 (MEM_TIMEOUT!=0): set mem_err (sticky until reset), force release as if
//      ready, go to RUN.
//  - REDIRECT: single cycle. ifid_flush=1 (wrong-path fetch in flight), all en=1, pc_sel_tgt=0.
//    - dmem stall still has priority -> MEM_WAIT, with the flush kept pending until the next cycle of
//      REDIRECT-equivalent output.
//    - Otherwise -> RUN.
//  - Simultaneous redirect_ex + load_hazard -> redirect wins.
//  - rst_n low mid-stall or mid-redirect: immediate return to BOOT, counters cleared.
//  - Counters saturate: no wrap.
// CONFIGURATION
//  PIPELINE_CTRL_PERF_CNT_EN defined adds output ports, each CNT_W wide, reset 0, saturating at all-ones:
//  - stall_cnt_o: +1 per load-hazard bubble
//  - flush_cnt_o: +1 per redirect
//  - memwait_cnt_o: +1 per MEM_WAIT cycle
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset, BOOT_CYCLES=3: release rst_n -> all en=0 / flush=1 for 3 cycles; 4th cycle all en=1, state_o=RUN.
//  2. RUN, load_hazard=1 for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle
//     all en=1.
//  3. redirect_ex=1 with load_hazard=1 -> pc_sel_tgt=1, ifid_flush=idex_flush=1, pc_en=1; next cycle
//     ifid_flush=1 only; then normal.
//  4. dmem_req=1, dmem_ready=0 for 5 cycles then 1 -> all en=0 for 5 cycles, release on 6th, state_o back to RUN.
//  5. MEM_TIMEOUT=4, dmem_ready held 0 -> after 4 stalled cycles mem_err=1 and pipeline released; mem_err stays
//     1 until rst_n.
//  6. rst_n pulsed low during MEM_WAIT -> state_o=BOOT immediately, mem_err=0, all en=0; with PERF_CNT_EN all
//     counters=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall/flush sequencer for a 5-stage RV32I pipeline.
//
// Combines the load-use hazard flag, the EX-stage redirect and the data-memory
// handshake into enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// After reset the pipeline is held flushed for BOOT_CYCLES cycles. A data-memory
// access that stays outstanding too long is force-released and flagged (mem_err).
//
// Optional feature macro: PIPELINE_CTRL_PERF_CNT_EN
//   When defined, adds saturating performance counters stall_cnt_o,
//   flush_cnt_o and memwait_cnt_o (CNT_W bits each).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   load_hazard           load-use hazard from hazard unit
//   redirect_ex           taken branch / JAL / JALR resolved in EX
//   dmem_req, dmem_ready  data-memory access present / completing this cycle
//   pc_en, pc_sel_tgt     PC load enable, PC source (1: EX target, 0: PC+4)
//   ifid_en, ifid_flush   IF/ID enable, clear to NOP
//   idex_en, idex_flush   ID/EX enable, clear controls
//   exmem_en, memwb_en    EX/MEM and MEM/WB enables
//   mem_err               sticky data-memory timeout flag
//   state_o               FSM state (BOOT=0, RUN=1, MEM_WAIT=2, REDIRECT=3)
//
// All control outputs are Mealy: derived from the current state and inputs.

module pipeline_ctrl #(
  parameter int BOOT_CYCLES = 3,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_hazard,
  input  logic             redirect_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_sel_tgt,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             mem_err,
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam int BW   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int TW   = $clog2(MEM_TIMEOUT + 2);
  localparam int TMAX = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t        state, nxt;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;
  logic          pend;       // redirect flush deferred by a memory stall

  logic mem_stall, to_hit, release_mw;
  logic do_boot, do_run, do_reflush, run_stall;
  logic hz_bubble, redir_take;

  assign mem_stall  = dmem_req & ~dmem_ready;
  assign to_hit     = (MEM_TIMEOUT != 0) && (tcnt == TW'(TMAX));
  assign release_mw = (state == MEM_WAIT) && (dmem_ready || to_hit);
  assign state_o    = state;

  // Next-state and outputs. Default is "freeze": all enables low, no flush.
  always_comb begin
    nxt        = state;
    do_boot    = 1'b0;
    do_run     = 1'b0;
    do_reflush = 1'b0;
    run_stall  = 1'b0;
    pc_en      = 1'b0;
    pc_sel_tgt = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    hz_bubble  = 1'b0;
    redir_take = 1'b0;

    case (state)
      BOOT: begin
        do_boot = 1'b1;
        if (bcnt == '0) nxt = RUN;
      end
      RUN: begin
        do_run    = 1'b1;
        run_stall = mem_stall;
      end
      MEM_WAIT: begin
        // Release (ready or timeout) looks like a RUN cycle with the memory
        // stall removed; a deferred redirect flush takes that slot instead.
        if (release_mw) begin
          if (pend) do_reflush = 1'b1;
          else      do_run     = 1'b1;
        end
      end
      REDIRECT: begin
        if (mem_stall) nxt = MEM_WAIT;
        else           do_reflush = 1'b1;
      end
      default: nxt = BOOT;
    endcase

    if (do_boot) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (do_reflush) begin
      // Wrong-path fetch still in flight: squash it, load_hazard is moot.
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      nxt        = RUN;
    end else if (do_run) begin
      if (run_stall) begin
        nxt = MEM_WAIT;
      end else if (redirect_ex) begin
        pc_en      = 1'b1;
        pc_sel_tgt = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        redir_take = 1'b1;
        nxt        = REDIRECT;
      end else if (load_hazard) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        hz_bubble  = 1'b1;
        nxt        = RUN;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        nxt      = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      bcnt    <= BW'(BOOT_CYCLES - 1);
      tcnt    <= '0;
      mem_err <= 1'b0;
      pend    <= 1'b0;
    end else begin
      state <= nxt;

      if (state == BOOT && bcnt != '0) bcnt <= bcnt - 1'b1;

      if (state == MEM_WAIT && !release_mw) begin
        if (tcnt != '1) tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end

      // Only a forced release counts as an error, not a real completion.
      if (state == MEM_WAIT && to_hit && !dmem_ready) mem_err <= 1'b1;

      if (state == REDIRECT && mem_stall) pend <= 1'b1;
      else if (do_reflush)                pend <= 1'b0;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
      memwait_cnt_o <= '0;
    end else begin
      if (hz_bubble && stall_cnt_o != '1)           stall_cnt_o   <= stall_cnt_o + 1'b1;
      if (redir_take && flush_cnt_o != '1)          flush_cnt_o   <= flush_cnt_o + 1'b1;
      if (state == MEM_WAIT && memwait_cnt_o != '1) memwait_cnt_o <= memwait_cnt_o + 1'b1;
    end
  end
`endif

endmodule
